// File: rtl/wb_line_fetch_pkg.sv
// Shared state encodings and fixed Wishbone control values for the line fetcher.
// The fetcher only ever reads full 16-bit words.
package wb_line_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] WB_SEL_WORD = 2'b11;
  localparam logic       WB_WE_READ  = 1'b0;

  localparam int WB_ADR_W = 17;
  localparam int WB_DAT_W = 16;

endpackage

// File: rtl/wb_line_fetch_if.sv
// Wishbone classic bus bundle between the line fetcher (master) and the SRAM slave.
// Signal names keep the master-side Wishbone naming.
interface wb_line_fetch_if;
  import wb_line_fetch_pkg::*;

  logic [WB_ADR_W-1:0] wbm_adr_o;
  logic [WB_DAT_W-1:0] wbm_dat_i;
  logic                wbm_we_o;
  logic [1:0]          wbm_sel_o;
  logic                wbm_stb_o;
  logic                wbm_cyc_o;
  logic                wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_we_o, wbm_sel_o, wbm_stb_o, wbm_cyc_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

// File: rtl/wb_fetch_fifo.sv
// First-word-fall-through FIFO: dout always shows the entry at the read pointer,
// so a consumer sees the head word in the same cycle valid is raised.
module wb_fetch_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          empty_reg, empty_next;
  logic          full_reg, full_next;
  logic          do_push, do_pop;

  assign do_push = push && !full_reg;
  assign do_pop  = pop && !empty_reg;

  // Pointers are exactly AW bits wide, so the power-of-two depth makes them wrap naturally.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + AW'(1);
    if (do_pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
    empty_next = (count_next == CW'(0));
    full_next  = (count_next == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      empty_reg  <= empty_next;
      full_reg   <= full_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !srst) mem[wr_ptr_reg] <= din;
  end

  assign dout  = mem[rd_ptr_reg];
  assign empty = empty_reg;
  assign full  = full_reg;
  assign count = count_reg;

  // The master only requests a word when a slot is free, so this must never fire.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (srst || flush)
    !(push && full_reg));

endmodule

// File: rtl/wb_line_fetch.sv
// Wishbone classic read master: fetches a block of len_i words from base_adr_i,
// one access at a time, into an FWFT FIFO that it never lets overflow.
module wb_line_fetch
  import wb_line_fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 10
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [WB_ADR_W-1:0] base_adr_i,
  input  logic [LEN_W-1:0]    len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [WB_DAT_W-1:0] dat_o,
  output logic                valid_o,
  input  logic                rd_i,
  wb_line_fetch_if.master     wb
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t              state_reg, state_next;
  logic [WB_ADR_W-1:0] adr_reg, adr_next;
  logic [LEN_W-1:0]    rem_reg, rem_next;
  logic                stb_reg, stb_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;

  logic                fifo_empty, fifo_full;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    level_after_pop;
  logic                pop_eff;
  logic                space_ok;
  logic                ack_take;

  // An abort wins over a same-cycle ack: the returned word is simply dropped.
  assign ack_take = wb.wbm_ack_i && stb_reg && !abort_i;
  assign pop_eff  = rd_i && !fifo_empty;

  // A pop in this cycle frees a slot early enough to request in the same cycle.
  assign level_after_pop = fifo_count - CNT_W'(pop_eff);
  assign space_ok        = (level_after_pop < CNT_W'(FIFO_DEPTH));

  wb_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WB_DAT_W)
  ) u_fifo (
    .clk   (wb_clk_i),
    .srst  (wb_rst_i),
    .flush (abort_i),
    .push  (ack_take),
    .pop   (rd_i),
    .din   (wb.wbm_dat_i),
    .dout  (dat_o),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // ST_REQ is exactly the set of cycles with stb/cyc high; ST_WAIT covers both the
  // mandatory one-cycle gap after each ack and waiting for FIFO space.
  always_comb begin
    state_next = state_reg;
    adr_next   = adr_reg;
    rem_next   = rem_reg;
    stb_next   = stb_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    if (abort_i) begin
      state_next = ST_IDLE;
      stb_next   = 1'b0;
      busy_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              adr_next  = base_adr_i;
              rem_next  = len_i;
              busy_next = 1'b1;
              if (space_ok) begin
                state_next = ST_REQ;
                stb_next   = 1'b1;
              end else begin
                state_next = ST_WAIT;
              end
            end else begin
              done_next = 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (ack_take) begin
            adr_next = adr_reg + WB_ADR_W'(1);
            rem_next = rem_reg - LEN_W'(1);
            stb_next = 1'b0;
            if (rem_reg == LEN_W'(1)) begin
              state_next = ST_IDLE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end else begin
              state_next = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (space_ok) begin
            state_next = ST_REQ;
            stb_next   = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          stb_next   = 1'b0;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= ST_IDLE;
      adr_reg   <= '0;
      rem_reg   <= '0;
      stb_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      adr_reg   <= adr_next;
      rem_reg   <= rem_next;
      stb_reg   <= stb_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign wb.wbm_adr_o = adr_reg;
  assign wb.wbm_stb_o = stb_reg;
  assign wb.wbm_cyc_o = stb_reg;
  assign wb.wbm_we_o  = WB_WE_READ;
  assign wb.wbm_sel_o = WB_SEL_WORD;

  assign busy_o  = busy_reg;
  assign done_o  = done_reg;
  assign valid_o = !fifo_empty;

  a_full_matches_count: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_wb_line_fetch.sv
// Directed bench for wb_line_fetch against a single-pulse-ack slave whose read data
// is a fixed function of the word address.
module tb_wb_line_fetch;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [16:0] base_adr = '0;
  logic [9:0]  len = '0;
  logic        rd = 1'b0;
  logic        busy, done, valid;
  logic [15:0] dat;
  logic        ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_n = 0;
  int last_ack_cyc = 0;
  int done_cnt = 0;
  int stb_cnt = 0;
  int cyc_bad = 0;
  logic [16:0] ack_q[$];
  logic [15:0] pop_q[$];

  wb_line_fetch_if bus ();

  wb_line_fetch #(.FIFO_DEPTH(8), .LEN_W(10)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (srst),
    .start_i    (start),
    .abort_i    (abort),
    .base_adr_i (base_adr),
    .len_i      (len),
    .busy_o     (busy),
    .done_o     (done),
    .dat_o      (dat),
    .valid_o    (valid),
    .rd_i       (rd),
    .wb         (bus)
  );

  always #5 clk = ~clk;

  // Slave: registered single-pulse ack, deliberately not reset so late acks are possible.
  always @(posedge clk) ack <= bus.wbm_stb_o & ~ack;
  assign bus.wbm_ack_i = ack;
  assign bus.wbm_dat_i = bus.wbm_adr_o[15:0] ^ 16'h5A5A;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (bus.wbm_stb_o && ack && !srst) begin
      ack_q.push_back(bus.wbm_adr_o);
      last_ack_cyc = cyc_n;
    end
    if (rd && valid && !srst) begin
      pop_q.push_back(dat);
      $display("[%0t] pop dat=0x%04h", $time, dat);
    end
    if (done) done_cnt++;
    if (bus.wbm_stb_o) stb_cnt++;
    if (bus.wbm_cyc_o !== bus.wbm_stb_o) cyc_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ack_q.delete();
    pop_q.delete();
    done_cnt = 0;
    stb_cnt = 0;
  endtask

  task automatic pulse_start(input logic [16:0] b, input logic [9:0] n);
    base_adr = b;
    len = n;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < bound) begin
      step();
      k++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic check_block(input string tag, input logic [16:0] b, input int n);
    logic [16:0] ea;
    check({tag, "_acks"}, 32'(ack_q.size()), 32'(n));
    check({tag, "_pops"}, 32'(pop_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      ea = b + 17'(i);
      if (i < ack_q.size()) check($sformatf("%s_adr%0d", tag, i), 32'(ack_q[i]), 32'(ea));
      if (i < pop_q.size()) check($sformatf("%s_dat%0d", tag, i), 32'(pop_q[i]), 32'(ea[15:0] ^ 16'h5A5A));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) step();
    // Reset values
    check("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
    check("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("rst_adr", 32'(bus.wbm_adr_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_we", 32'(bus.wbm_we_o), 32'd0);
    check("rst_sel", 32'(bus.wbm_sel_o), 32'h3);
    srst = 1'b0;
    step();

    // 1: basic 4-word block, consumer always ready
    clear_logs();
    rd = 1'b1;
    pulse_start(17'h00100, 10'd4);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    wait_done(100, "t1");
    check("t1_done_latency", 32'(cyc_n - last_ack_cyc), 32'd1);
    check("t1_busy_falls", 32'(busy), 32'd0);
    repeat (3) step();
    check_block("t1", 17'h00100, 4);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);

    // 2: FIFO fills and throttles the bus, then drains
    clear_logs();
    rd = 1'b0;
    pulse_start(17'h00200, 10'd12);
    repeat (40) step();
    check("t2_acks_full", 32'(ack_q.size()), 32'd8);
    check("t2_stb_held_low", 32'(bus.wbm_stb_o), 32'd0);
    check("t2_valid", 32'(valid), 32'd1);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_head", 32'(dat), 32'(16'h0200 ^ 16'h5A5A));
    rd = 1'b1;
    wait_done(200, "t2");
    repeat (3) step();
    check_block("t2", 17'h00200, 12);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);

    // 3: address wraps at the top of the 17-bit space
    clear_logs();
    pulse_start(17'h1FFFE, 10'd3);
    wait_done(100, "t3");
    repeat (3) step();
    check_block("t3", 17'h1FFFE, 3);

    // 4: zero-length block
    clear_logs();
    base_adr = 17'h00050;
    len = 10'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_done", 32'(done), 32'd1);
    check("t4_busy", 32'(busy), 32'd0);
    step();
    check("t4_done_drop", 32'(done), 32'd0);
    repeat (3) step();
    check("t4_no_stb", 32'(stb_cnt), 32'd0);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);

    // 5: abort coinciding with an ack
    clear_logs();
    rd = 1'b0;
    pulse_start(17'h00300, 10'd5);
    k = 0;
    while (!(bus.wbm_stb_o && ack && ack_q.size() == 1) && k < 100) begin
      step();
      k++;
    end
    check("t5_reached_ack", 32'(bus.wbm_stb_o && ack), 32'd1);
    check("t5_pre_valid", 32'(valid), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_stb", 32'(bus.wbm_stb_o), 32'd0);
    check("t5_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    repeat (5) step();
    check("t5_done_cnt", 32'(done_cnt), 32'd0);
    check("t5_stays_idle", 32'(bus.wbm_stb_o), 32'd0);
    clear_logs();
    rd = 1'b1;
    pulse_start(17'h00400, 10'd2);
    wait_done(100, "t5b");
    repeat (3) step();
    check_block("t5b", 17'h00400, 2);

    // 6: reset mid-block with a late ack after it
    clear_logs();
    rd = 1'b0;
    pulse_start(17'h00500, 10'd6);
    k = 0;
    while (!(ack_q.size() == 3 && bus.wbm_stb_o && !ack) && k < 100) begin
      step();
      k++;
    end
    check("t6_pre_valid", 32'(valid), 32'd1);
    srst = 1'b1;
    step();
    srst = 1'b0;
    check("t6_stb", 32'(bus.wbm_stb_o), 32'd0);
    check("t6_cyc", 32'(bus.wbm_cyc_o), 32'd0);
    check("t6_adr", 32'(bus.wbm_adr_o), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_valid", 32'(valid), 32'd0);
    check("t6_late_ack", 32'(ack), 32'd1);
    step();
    check("t6_valid_after_late_ack", 32'(valid), 32'd0);
    repeat (3) step();
    check("t6_no_new_acks", 32'(ack_q.size()), 32'd3);
    check("t6_busy_idle", 32'(busy), 32'd0);

    check("cyc_equals_stb", 32'(cyc_bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
